// File: rtl/bpu_pkg.sv
// Shared branch-prediction-unit definitions.
//   - ctr_t and the CTR_* encodings of the two-bit saturating counter
//     (the MSB is the predicted direction).
//   - CTR_RST, the value that table initialisation writes.
//   - pht_state_e, the table initialisation / run state.
package bpu_pkg;

  localparam int CTR_W = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

  localparam ctr_t CTR_RST = CTR_SNT;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

endpackage

// File: rtl/bpu_ctr_next.sv
// Two-bit saturating counter next-state (combinational).
// Ports:
//   ctr      current counter value
//   taken    resolved direction (1 = taken)
//   ctr_nxt  counter moved one step toward the outcome, saturating at
//            CTR_ST on taken and at CTR_SNT on not-taken
module bpu_ctr_next
  import bpu_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_nxt = ctr + ctr_t'(1);
    end else begin
      if (ctr != CTR_SNT) ctr_nxt = ctr - ctr_t'(1);
    end
  end

endmodule

// File: rtl/bpu_pht.sv
// Gshare pattern history table.
// 2^IDX_W two-bit counters indexed by (PC >> ALIGN) XOR the global history.
// After reset the table clears one entry per clock (INIT), then raises
// out_ready and serves one lookup plus one update per cycle (RUN).
// The history register is trained only by resolved branches.
// Ports:
//   in_Clk, in_Rst_N   clock, asynchronous active-low reset
//   out_ready          table initialised
//   in_lookup_valid/in_lookup_pc            fetch lookup request
//   out_pred_valid/out_pred_taken/out_pred_idx  registered prediction,
//                                           one cycle after the request
//   in_upd_valid/in_upd_idx/in_upd_taken    branch resolution from execute
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int PC_W  = 64,
  parameter int IDX_W = 10,
  parameter int GHR_W = 8,
  parameter int ALIGN = 2
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  output logic             out_ready,
  input  logic             in_lookup_valid,
  input  logic [PC_W-1:0]  in_lookup_pc,
  output logic             out_pred_valid,
  output logic             out_pred_taken,
  output logic [IDX_W-1:0] out_pred_idx,
  input  logic             in_upd_valid,
  input  logic [IDX_W-1:0] in_upd_idx,
  input  logic             in_upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  pht_state_e       state;
  logic [IDX_W-1:0] init_ptr;
  logic [GHR_W-1:0] ghr;
  ctr_t             pht [DEPTH];

  logic             ready_p1;
  logic             vld_p1;
  logic             pred_taken_p1;
  logic [IDX_W-1:0] pred_idx_p1;

  logic [IDX_W-1:0] lk_idx_p0;
  ctr_t             lk_ctr_p0;
  ctr_t             upd_cur_p0;
  ctr_t             upd_nxt_p0;
  logic             upd_en_p0;
  logic             unused_pc;

  // Stage p0: index hash, counter read, update next-state and bypass.
  // The hash uses the history before any same-edge shift.
  assign lk_idx_p0  = in_lookup_pc[IDX_W+ALIGN-1:ALIGN] ^ IDX_W'(ghr);
  assign upd_en_p0  = in_upd_valid && (state == ST_RUN);
  assign upd_cur_p0 = pht[in_upd_idx];
  assign unused_pc  = ^{in_lookup_pc[PC_W-1:IDX_W+ALIGN], in_lookup_pc[ALIGN-1:0]};

  bpu_ctr_next u_ctr_next (
    .ctr     (upd_cur_p0),
    .taken   (in_upd_taken),
    .ctr_nxt (upd_nxt_p0)
  );

  // A same-cycle update to the looked-up entry is forwarded so the
  // prediction reflects the counter as it will be after this edge.
  always_comb begin
    lk_ctr_p0 = pht[lk_idx_p0];
    if (upd_en_p0 && (in_upd_idx == lk_idx_p0)) lk_ctr_p0 = upd_nxt_p0;
  end

  // Counter storage is data only: it is cleared by the INIT sweep,
  // not by the asynchronous reset.
  always_ff @(posedge in_Clk) begin
    if (state == ST_INIT) begin
      pht[init_ptr] <= CTR_RST;
    end else if (in_upd_valid) begin
      pht[in_upd_idx] <= upd_nxt_p0;
    end
  end

  // Stage p1: registered prediction and control state.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state         <= ST_INIT;
      init_ptr      <= '0;
      ghr           <= '0;
      ready_p1      <= 1'b0;
      vld_p1        <= 1'b0;
      pred_taken_p1 <= 1'b0;
      pred_idx_p1   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          vld_p1   <= 1'b0;
          init_ptr <= init_ptr + IDX_W'(1);
          if (init_ptr == IDX_W'(DEPTH - 1)) begin
            state    <= ST_RUN;
            ready_p1 <= 1'b1;
          end
        end
        ST_RUN: begin
          vld_p1 <= in_lookup_valid;
          if (in_lookup_valid) begin
            pred_taken_p1 <= lk_ctr_p0[CTR_W-1];
            pred_idx_p1   <= lk_idx_p0;
          end
          // Shift-left form also covers a one-bit history.
          if (in_upd_valid) ghr <= (ghr << 1) | GHR_W'(in_upd_taken);
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign out_ready      = ready_p1;
  assign out_pred_valid = vld_p1;
  assign out_pred_taken = pred_taken_p1;
  assign out_pred_idx   = pred_idx_p1;

endmodule

// File: doc/bpu_pht.md
Name: bpu_pht

Overview:
- Gshare pattern history table for the branch prediction unit.
- Holds 2^IDX_W two-bit saturating counters, indexed by fetch PC XOR global history register (GHR).
- Gives the fetch stage a taken/not-taken prediction one cycle after lookup.
- Consumes branch resolutions from execute to train the counters and shift the GHR (non-speculative history).

Parameters:
- PC_W, 64, fetch/resolve PC width.
- IDX_W, 10, table index width; the table has 2^IDX_W entries.
- GHR_W, 8, global history length; legal range 1..IDX_W.
- ALIGN, 2, PC low bits dropped before indexing.

Ports:
- in_Clk  input  1  clock.
- in_Rst_N  input  1  reset, asynchronous, active-low.
- out_ready  output  1  table initialised; lookups and updates are accepted.
- in_lookup_valid  input  1  fetch lookup request.
- in_lookup_pc  input  PC_W  PC of the fetched branch.
- out_pred_valid  output  1  prediction valid, one cycle after the request.
- out_pred_taken  output  1  predicted direction (1 = taken).
- out_pred_idx  output  IDX_W  index used; travels down the pipe to the update port.
- in_upd_valid  input  1  branch resolution strobe.
- in_upd_idx  input  IDX_W  index returned from out_pred_idx.
- in_upd_taken  input  1  actual branch outcome.

Behaviour:
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Prediction = counter[1].
- Next-state: taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Reset (async, any time, including mid-operation):
  - state = INIT, init_ptr = 0, ghr = 0.
  - out_ready = 0, out_pred_valid = 0, out_pred_taken = 0, out_pred_idx = 0.
  - Table contents are not reset asynchronously.
- INIT state:
  - Each edge writes 00 to entry init_ptr, then init_ptr increments.
  - On the edge that writes entry 2^IDX_W-1, state becomes RUN and out_ready becomes 1.
  - out_ready therefore rises at the 2^IDX_W-th edge after reset release.
  - Lookups are ignored and out_pred_valid stays 0. Updates are dropped and the GHR is unchanged.
- RUN state:
  - Index: idx = in_lookup_pc[IDX_W+ALIGN-1:ALIGN] XOR zero-extended ghr. The GHR value used is the one before any same-edge shift.
  - Lookup latency is 1 cycle: out_pred_valid <= in_lookup_valid every edge.
  - When the lookup is valid: out_pred_taken <= counter[1] and out_pred_idx <= idx.
  - When the lookup is not valid: out_pred_taken and out_pred_idx hold their values.
  - Update: when in_upd_valid is high, the edge writes next(counter[in_upd_idx], in_upd_taken) as a single read-modify-write, and ghr <= {ghr[GHR_W-2:0], in_upd_taken}. For GHR_W=1, ghr <= in_upd_taken.
  - A lookup and an update may occur in the same cycle; one of each is accepted per cycle.
  - Same-cycle lookup and update to the same index: the prediction uses the post-update counter value (bypass).
  - Different indices in the same cycle: the two operations are independent.
- No back-pressure: fetch and execute never stall on this block once out_ready = 1.
- All outputs are registered.

Decomposition:
- Shared package bpu_pkg holds:
  - counter width and the encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - the counter reset value (CTR_SNT);
  - the INIT/RUN state encoding.
- Sub-module bpu_ctr_next: purely combinational 2-bit saturating next-state. It is reused by the update path and the bypass path, and later by other BPU tables.
- The counter array lives in bpu_pht as a register array with a combinational read port.

Test Plan (IDX_W=4, GHR_W=4, ALIGN=2):
- Init: release reset; hold in_lookup_valid=1 with PC=0x24 throughout INIT -> out_pred_valid stays 0; out_ready = 1 exactly at the 16th edge; pulses of in_upd_valid during INIT leave ghr = 0.
- First lookup: with ghr=0, lookup PC=0x24 -> next cycle out_pred_valid=1, out_pred_taken=0, out_pred_idx=9.
- Training: three updates idx=9 taken=1 on consecutive cycles -> ghr=0111. Then lookup PC=0x38 (0xE XOR 0x7 = 9) -> out_pred_idx=9, out_pred_taken=1.
- Saturation/hysteresis: one more taken at idx=9 keeps the counter at 11. A not-taken gives 10 (predict 1). A second not-taken gives 01 (predict 0); ghr=1100 afterwards.
- Bypass: entry 3 at 01. In the same cycle, update idx=3 taken=1 and lookup whose index evaluates to 3 with the pre-shift ghr -> out_pred_taken=1.
- Reset mid-run: assert in_Rst_N=0 while out_pred_valid=1 -> out_pred_valid, out_pred_taken and out_ready drop immediately. After release, 16 init cycles, then entry 9 predicts 0 again.
